rfbw_ic_refill: RTL and testbench

RFBW_IC_REFILL -- requirements
Module: rfbw_ic_refill

---
 rtl/rfbw_ic_refill.sv | 170 +++++++++++++++++
 tb/tb_rfbw_ic_refill.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfbw_ic_refill.sv
// Instruction-cache miss handler: tag compare on the registered fetch address,
// 8-beat line refill into the data RAM, tag install into a round-robin victim way.
module rfbw_ic_refill #(
    parameter int unsigned AWID  = 32,
    parameter int unsigned BEATS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AWID-1:0] i_ip,
    input  logic            i_ip_v,
    input  logic [AWID-8:0] i_tag [0:3],
    output logic            o_hit,
    output logic [1:0]      o_hit_way,
    output logic            o_busy,
    output logic            o_mem_req,
    output logic [AWID-1:0] o_mem_adr,
    input  logic            i_mem_ack,
    input  logic [127:0]    i_mem_dat,
    input  logic            i_mem_err,
    output logic            o_dwr,
    output logic [11:0]     o_dwr_adr,
    output logic [127:0]    o_dwr_dat,
    output logic            o_tag_wr,
    output logic [AWID-1:0] o_tag_ipo,
    output logic [1:0]      o_tag_way,
    output logic            o_fault
);

    localparam int unsigned   BW   = $clog2(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_TAGUPD,
        S_SETTLE
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [AWID-8:0] r_rip;
    logic            r_rip_v;
    logic [BW-1:0]   r_beat;
    logic [1:0]      r_rr;
    logic [1:0]      r_victim;

    logic [3:0]      w_match;
    logic [1:0]      w_low_way;
    logic            w_lookup;
    logic            w_hit;
    logic            w_miss;
    logic            w_unused_ip_lo;

    // Line offset bits never take part in lookup or refill addressing.
    assign w_unused_ip_lo = ^i_ip[6:0];

    assign w_lookup = (r_state == S_IDLE) && r_rip_v;
    assign w_hit    = w_lookup && (|w_match);
    assign w_miss   = w_lookup && !(|w_match);

    // Per-way tag compare against the registered fetch address.
    always_comb begin
        w_match = '0;
        for (int unsigned w = 0; w < 4; w++) begin
            w_match[w] = (i_tag[w] == r_rip);
        end
    end

    // Lowest-numbered matching way wins (scan high to low, last write wins).
    always_comb begin
        w_low_way = 2'd0;
        for (int unsigned w = 0; w < 4; w++) begin
            if (w_match[3 - w]) begin
                w_low_way = 2'(3 - w);
            end
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (w_miss) w_state_nx = S_FETCH;
            S_FETCH: begin
                if (i_mem_err) begin
                    w_state_nx = S_IDLE;
                end else if (i_mem_ack && (r_beat == LAST)) begin
                    w_state_nx = S_TAGUPD;
                end
            end
            S_TAGUPD: w_state_nx = S_SETTLE;
            S_SETTLE: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // State register plus fetch-address capture, beat, victim and round-robin counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_rip    <= '0;
            r_rip_v  <= 1'b0;
            r_beat   <= '0;
            r_rr     <= 2'd0;
            r_victim <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            case (r_state)
                S_IDLE: begin
                    // On a miss the captured address is held so the refill targets
                    // the missing line rather than whatever is presented next.
                    if (w_miss) begin
                        r_beat   <= '0;
                        r_victim <= r_rr;
                    end else begin
                        r_rip   <= i_ip[AWID-1:7];
                        r_rip_v <= i_ip_v;
                    end
                end
                S_FETCH: begin
                    if (i_mem_err) begin
                        r_rip_v <= 1'b0;
                    end else if (i_mem_ack) begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                S_TAGUPD: r_rr <= r_rr + 2'd1;
                default: ;
            endcase
        end
    end

    // Output decode; everything is forced to zero while reset is asserted.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_way = 2'd0;
        o_busy    = 1'b0;
        o_mem_req = 1'b0;
        o_mem_adr = '0;
        o_dwr     = 1'b0;
        o_dwr_adr = '0;
        o_dwr_dat = '0;
        o_tag_wr  = 1'b0;
        o_tag_ipo = '0;
        o_tag_way = 2'd0;
        o_fault   = 1'b0;
        if (!i_rst) begin
            o_busy    = (r_state != S_IDLE);
            o_hit     = w_hit;
            o_hit_way = w_hit ? w_low_way : 2'd0;
            case (r_state)
                S_FETCH: begin
                    o_mem_req = 1'b1;
                    o_mem_adr = {r_rip, r_beat, 4'b0000};
                    o_dwr     = i_mem_ack && !i_mem_err;
                    o_dwr_adr = {r_victim, r_rip[6:0], r_beat};
                    o_dwr_dat = i_mem_dat;
                    o_fault   = i_mem_err;
                end
                S_TAGUPD: begin
                    o_tag_wr  = 1'b1;
                    o_tag_ipo = {r_rip, 7'b0000000};
                    o_tag_way = r_victim;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rfbw_ic_refill.sv
// Bench for rfbw_ic_refill: a tag-array environment with registered read, and a
// reference cache directory (per-set way tags plus round-robin pointer).
module tb_rfbw_ic_refill;

    logic         clk;
    logic         rst;
    logic [31:0]  ip;
    logic         ip_v;
    logic [24:0]  tag_bus [0:3];
    logic         o_hit;
    logic [1:0]   o_hit_way;
    logic         o_busy;
    logic         o_mem_req;
    logic [31:0]  o_mem_adr;
    logic         mem_ack;
    logic [127:0] mem_dat;
    logic         mem_err;
    logic         o_dwr;
    logic [11:0]  o_dwr_adr;
    logic [127:0] o_dwr_dat;
    logic         o_tag_wr;
    logic [31:0]  o_tag_ipo;
    logic [1:0]   o_tag_way;
    logic         o_fault;

    int n_cmp = 0;
    int n_bad = 0;

    rfbw_ic_refill #(.AWID(32), .BEATS(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_ip(ip), .i_ip_v(ip_v), .i_tag(tag_bus),
        .o_hit(o_hit), .o_hit_way(o_hit_way), .o_busy(o_busy),
        .o_mem_req(o_mem_req), .o_mem_adr(o_mem_adr), .i_mem_ack(mem_ack),
        .i_mem_dat(mem_dat), .i_mem_err(mem_err), .o_dwr(o_dwr),
        .o_dwr_adr(o_dwr_adr), .o_dwr_dat(o_dwr_dat), .o_tag_wr(o_tag_wr),
        .o_tag_ipo(o_tag_ipo), .o_tag_way(o_tag_way), .o_fault(o_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tag-array environment: registered read indexed by ip, written by the DUT.
    logic [24:0] env_tags [0:127][0:3];
    logic [6:0]  rd_idx;
    logic        pl_en, pl_clr;
    logic [6:0]  pl_set;
    logic [1:0]  pl_way;
    logic [24:0] pl_tag;

    always @(posedge clk) begin
        rd_idx <= ip[13:7];
        if (pl_clr) begin
            for (int s = 0; s < 128; s++)
                for (int w = 0; w < 4; w++) env_tags[s][w] <= '1;
        end else if (o_tag_wr) begin
            env_tags[o_tag_ipo[13:7]][o_tag_way] <= o_tag_ipo[31:7];
        end else if (pl_en) begin
            env_tags[pl_set][pl_way] <= pl_tag;
        end
    end

    always_comb begin
        for (int w = 0; w < 4; w++) tag_bus[w] = env_tags[rd_idx][w];
    end

    // Reference directory: what the cache should contain, and the next victim.
    logic [24:0] ref_tags [0:127][0:3];
    int          ref_rr;

    function automatic int ref_lookup(input logic [31:0] a);
        for (int w = 0; w < 4; w++) begin
            if (ref_tags[a[13:7]][w] == a[31:7]) return w;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; ip = $urandom; ip_v = 1'b1; mem_ack = 1'b1; mem_err = 1'b1;
        pl_clr = 1'b1;
        for (int s = 0; s < 128; s++)
            for (int w = 0; w < 4; w++) ref_tags[s][w] = '1;
        ref_rr = 0;
        @(posedge clk); #1;
        pl_clr = 1'b0;
        #1;
        n_cmp++;
        if ({o_hit, o_busy, o_mem_req, o_dwr, o_tag_wr, o_fault, o_hit_way} !== 8'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {o_hit, o_busy, o_mem_req, o_dwr, o_tag_wr, o_fault, o_hit_way});
        end
        n_cmp++;
        if ({o_mem_adr, o_dwr_adr, o_tag_ipo, o_tag_way} !== 78'b0) begin
            n_bad++;
            $display("FAIL reset_buses: mem_adr %h dwr_adr %h tag_ipo %h tag_way %0d want all 0",
                     o_mem_adr, o_dwr_adr, o_tag_ipo, o_tag_way);
        end
        @(posedge clk); #1;
        rst = 1'b0; ip_v = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
    endtask

    task automatic preload(input logic [6:0] set, input logic [1:0] way, input logic [24:0] t);
        @(posedge clk); #1;
        ip_v = 1'b0; pl_en = 1'b1; pl_set = set; pl_way = way; pl_tag = t;
        ref_tags[set][way] = t;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One fetch: lookup, and on a miss the full refill/abort sequence.
    task automatic run_access(input logic [31:0] addr, input int ack_pct, input int err_beat,
                              input int rst_beat, output int got_way, output bit was_miss);
        int         exp_way, beat, ndwr, cyc;
        logic       exp_hit, ack, err;
        logic [1:0] exp_hw, victim;
        got_way = -1; was_miss = 1'b0;

        @(posedge clk); #1;
        ip = addr; ip_v = 1'b1; mem_ack = 1'($urandom); mem_err = 1'($urandom);
        mem_dat = {$urandom, $urandom, $urandom, $urandom};
        #1;
        n_cmp++;
        if ({o_hit, o_busy, o_mem_req, o_dwr, o_tag_wr, o_fault} !== 6'b0) begin
            n_bad++;
            $display("FAIL idle_quiet: got %b want 000000",
                     {o_hit, o_busy, o_mem_req, o_dwr, o_tag_wr, o_fault});
        end

        @(posedge clk); #1;
        mem_ack = 1'($urandom); mem_err = 1'($urandom);
        #1;
        exp_way = ref_lookup(addr);
        exp_hit = (exp_way >= 0);
        exp_hw  = exp_hit ? 2'(exp_way) : 2'b00;
        n_cmp++;
        if ({o_hit, o_hit_way, o_busy, o_mem_req, o_dwr, o_fault} !== {exp_hit, exp_hw, 4'b0}) begin
            n_bad++;
            $display("FAIL lookup %h: hit/way/busy/req/dwr/fault got %b want %b",
                     addr, {o_hit, o_hit_way, o_busy, o_mem_req, o_dwr, o_fault}, {exp_hit, exp_hw, 4'b0});
        end

        if (exp_hit) begin
            @(posedge clk); #1;
            ip_v = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
            #1;
            n_cmp++;
            if ({o_hit, o_hit_way, o_busy, o_mem_req} !== {1'b1, exp_hw, 2'b0}) begin
                n_bad++;
                $display("FAIL hit_hold: got %b want %b", {o_hit, o_hit_way, o_busy, o_mem_req},
                         {1'b1, exp_hw, 2'b0});
            end
            return;
        end

        was_miss = 1'b1;
        victim = 2'(ref_rr);
        beat = 0; ndwr = 0; cyc = 0;
        while (beat < 8) begin
            @(posedge clk); #1;
            ip = $urandom; ip_v = 1'($urandom);
            mem_dat = {$urandom, $urandom, $urandom, $urandom};
            err = (beat == err_beat);
            ack = ($urandom_range(0, 99) < ack_pct);
            if (beat == rst_beat) begin
                ack = 1'b1; err = 1'b0; rst = 1'b1;
            end
            mem_ack = ack; mem_err = err;
            #1;
            if (beat == rst_beat) begin
                n_cmp++;
                if ({o_hit, o_busy, o_mem_req, o_dwr, o_tag_wr, o_fault, o_mem_adr, o_dwr_adr} !== 50'b0) begin
                    n_bad++;
                    $display("FAIL rst_mid_outputs: req %b busy %b dwr %b adr %h want 0",
                             o_mem_req, o_busy, o_dwr, o_mem_adr);
                end
                @(posedge clk); #1;
                rst = 1'b0; ip_v = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
                #1;
                n_cmp++;
                if ({o_mem_req, o_busy, o_tag_wr, o_dwr, o_hit} !== 5'b0) begin
                    n_bad++;
                    $display("FAIL rst_mid_after: req/busy/tag_wr/dwr/hit got %b want 00000",
                             {o_mem_req, o_busy, o_tag_wr, o_dwr, o_hit});
                end
                ref_rr = 0;
                return;
            end
            n_cmp++;
            if ({o_mem_req, o_busy, o_tag_wr, o_hit, o_fault, o_dwr} !== {4'b1100, err, ack && !err}) begin
                n_bad++;
                $display("FAIL fetch_flags beat %0d: req/busy/tag_wr/hit/fault/dwr got %b want %b", beat,
                         {o_mem_req, o_busy, o_tag_wr, o_hit, o_fault, o_dwr}, {4'b1100, err, ack && !err});
            end
            n_cmp++;
            if (o_mem_adr !== {addr[31:7], 3'(beat), 4'b0}) begin
                n_bad++;
                $display("FAIL mem_adr beat %0d: got %h want %h", beat, o_mem_adr, {addr[31:7], 3'(beat), 4'b0});
            end
            if (o_dwr) ndwr++;
            if (ack && !err) begin
                n_cmp++;
                if ({o_dwr_adr, o_dwr_dat} !== {victim, addr[13:7], 3'(beat), mem_dat}) begin
                    n_bad++;
                    $display("FAIL dwr_beat %0d: adr got %h want %h", beat, o_dwr_adr,
                             {victim, addr[13:7], 3'(beat)});
                end
            end
            if (err) begin
                @(posedge clk); #1;
                ip_v = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
                #1;
                n_cmp++;
                if ({o_busy, o_mem_req, o_fault, o_hit, o_tag_wr, o_dwr} !== 6'b0) begin
                    n_bad++;
                    $display("FAIL err_after: got %b want 000000",
                             {o_busy, o_mem_req, o_fault, o_hit, o_tag_wr, o_dwr});
                end
                @(posedge clk); #1;
                #1;
                n_cmp++;
                if ({o_busy, o_tag_wr} !== 2'b0) begin
                    n_bad++;
                    $display("FAIL err_settled: busy/tag_wr got %b want 00", {o_busy, o_tag_wr});
                end
                n_cmp++;
                if (ndwr !== err_beat) begin
                    n_bad++;
                    $display("FAIL err_dwr_count: got %0d want %0d", ndwr, err_beat);
                end
                return;
            end
            if (ack) beat++;
            cyc++;
            if (cyc > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL refill_timeout: beat %0d after %0d cycles", beat, cyc);
                apply_reset();
                return;
            end
        end

        @(posedge clk); #1;
        ip = $urandom; ip_v = 1'($urandom); mem_ack = 1'($urandom); mem_err = 1'($urandom);
        #1;
        n_cmp++;
        if ({o_tag_wr, o_busy, o_mem_req, o_dwr, o_fault, o_hit} !== 6'b110000) begin
            n_bad++;
            $display("FAIL tagupd_flags: got %b want 110000",
                     {o_tag_wr, o_busy, o_mem_req, o_dwr, o_fault, o_hit});
        end
        n_cmp++;
        if ({o_tag_ipo, o_tag_way} !== {addr[31:7], 7'b0, victim}) begin
            n_bad++;
            $display("FAIL tag_write: ipo %h way %0d want %h way %0d", o_tag_ipo, o_tag_way,
                     {addr[31:7], 7'b0}, victim);
        end
        n_cmp++;
        if (ndwr !== 8) begin
            n_bad++;
            $display("FAIL dwr_count: got %0d want 8", ndwr);
        end
        got_way = int'(o_tag_way);
        ref_tags[addr[13:7]][victim] = addr[31:7];
        ref_rr = (ref_rr + 1) % 4;

        @(posedge clk); #1;
        ip = addr; ip_v = 1'($urandom); mem_ack = 1'($urandom); mem_err = 1'($urandom);
        #1;
        n_cmp++;
        if ({o_busy, o_mem_req, o_dwr, o_fault, o_tag_wr, o_hit} !== 6'b100000) begin
            n_bad++;
            $display("FAIL settle_flags: got %b want 100000",
                     {o_busy, o_mem_req, o_dwr, o_fault, o_tag_wr, o_hit});
        end

        @(posedge clk); #1;
        ip = $urandom; ip_v = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
        #1;
        exp_way = ref_lookup(addr);
        n_cmp++;
        if ({o_hit, o_hit_way, o_busy} !== {1'b1, 2'(exp_way), 1'b0}) begin
            n_bad++;
            $display("FAIL post_refill_hit: hit/way/busy got %b want %b",
                     {o_hit, o_hit_way, o_busy}, {1'b1, 2'(exp_way), 1'b0});
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge clk); #1;
        #1;
        n_cmp++;
        if ({o_busy, o_hit, o_mem_req} !== 3'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b want 000", {o_busy, o_hit, o_mem_req});
        end
    endtask

    task automatic test_hit();
        int gw; bit miss;
        apply_reset();
        preload(7'h45, 2'd2, 25'h0012345);
        preload(7'h45, 2'd0, 25'h0012346);
        preload(7'h45, 2'd3, 25'h1012345);
        run_access(32'h0091_A280, 100, -1, -1, gw, miss);
        n_cmp++;
        if (miss !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_no_refill: miss got %0b want 0", miss);
        end
    endtask

    task automatic test_miss_refill();
        int gw; bit miss;
        apply_reset();
        run_access(32'h0000_1A80, 100, -1, -1, gw, miss);
        n_cmp++;
        if ({miss, 2'(gw)} !== 3'b100) begin
            n_bad++;
            $display("FAIL miss_refill: miss %0b way %0d want miss 1 way 0", miss, gw);
        end
    endtask

    task automatic test_round_robin();
        int gw; bit miss;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_access({1'b0, 17'(i + 100), 7'(i * 9), 7'($urandom)}, 60, -1, -1, gw, miss);
            n_cmp++;
            if (gw !== i % 4) begin
                n_bad++;
                $display("FAIL round_robin %0d: way got %0d want %0d", i, gw, i % 4);
            end
        end
    endtask

    task automatic test_error();
        int gw; bit miss;
        apply_reset();
        run_access(32'h0004_3300, 100, 3, -1, gw, miss);
        run_access(32'h0004_3300, 100, -1, -1, gw, miss);
        n_cmp++;
        if ({miss, 2'(gw)} !== 3'b100) begin
            n_bad++;
            $display("FAIL after_error: miss %0b way %0d want miss 1 way 0", miss, gw);
        end
    endtask

    task automatic test_multi_match();
        int gw; bit miss;
        apply_reset();
        preload(7'h45, 2'd1, 25'h0012345);
        preload(7'h45, 2'd3, 25'h0012345);
        run_access(32'h0091_A2C4, 100, -1, -1, gw, miss);
        n_cmp++;
        if (miss !== 1'b0) begin
            n_bad++;
            $display("FAIL multi_match: miss got %0b want 0", miss);
        end
    endtask

    task automatic test_reset_mid_refill();
        int gw; bit miss;
        apply_reset();
        run_access(32'h0007_0100, 100, -1, -1, gw, miss);
        run_access(32'h0008_0200, 100, -1, 5, gw, miss);
        run_access(32'h0008_0200, 100, -1, -1, gw, miss);
        n_cmp++;
        if ({miss, 2'(gw)} !== 3'b100) begin
            n_bad++;
            $display("FAIL after_mid_reset: miss %0b way %0d want miss 1 way 0", miss, gw);
        end
    endtask

    task automatic test_random();
        int gw, eb; bit miss;
        logic [24:0] t;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            t  = {1'b0, 17'($urandom_range(1, 5)), 7'($urandom_range(0, 3) * 37)};
            eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_access({t, 7'($urandom)}, int'($urandom_range(40, 100)), eb, -1, gw, miss);
        end
    endtask

    initial begin
        rst = 1'b1; ip = '0; ip_v = 1'b0; mem_ack = 1'b0; mem_err = 1'b0; mem_dat = '0;
        pl_en = 1'b0; pl_clr = 1'b0; pl_set = '0; pl_way = '0; pl_tag = '0;
        test_reset();
        test_hit();
        test_miss_refill();
        test_round_robin();
        test_error();
        test_multi_match();
        test_reset_mid_refill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
